// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode values, instruction field geometry and
// the fetch front-end state encoding.
package isa_pkg;

    localparam int OPC_W = 4;
    localparam int IMM_W = 6;
    localparam int RT_W  = 3;

    localparam logic [OPC_W-1:0] OP_TBD    = 4'd0;
    localparam logic [OPC_W-1:0] OP_HALT   = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'd2;
    localparam logic [OPC_W-1:0] OP_WR     = 4'd3;
    localparam logic [OPC_W-1:0] OP_SEARCH = 4'd4;
    localparam logic [OPC_W-1:0] OP_BEQ    = 4'd5;
    localparam logic [OPC_W-1:0] OP_WM     = 4'd6;
    localparam logic [OPC_W-1:0] OP_SMR    = 4'd7;
    localparam logic [OPC_W-1:0] OP_RXOR   = 4'd8;
    localparam logic [OPC_W-1:0] OP_SRL    = 4'd9;
    localparam logic [OPC_W-1:0] OP_BSQ    = 4'd10;

    // DRAIN: halt word captured, waiting for decode to take it.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus: ROM address/data, decode valid/ready handshake and the
// PC redirect coming back from execute.
interface inst_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 10
);
    logic [ADDR_W-1:0] InstAddress;
    logic [INST_W-1:0] InstIn;
    logic              InstValid;
    logic              InstReady;
    logic [INST_W-1:0] Inst;
    logic [ADDR_W-1:0] InstPC;
    logic              Redirect;
    logic [ADDR_W-1:0] RedirectPC;

    modport master (
        output InstAddress, InstValid, Inst, InstPC,
        input  InstIn, InstReady, Redirect, RedirectPC
    );

    modport slave (
        input  InstAddress, InstValid, Inst, InstPC,
        output InstIn, InstReady, Redirect, RedirectPC
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC, ROM word capture register and fetch FSM.
// Optional INST_FETCH_PERF_EN adds saturating fetch/flush counters.
module inst_fetch
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic         Halted,
    inst_fetch_if.master bus
`ifdef INST_FETCH_PERF_EN
   ,output logic [15:0]  FetchCount,
    output logic [15:0]  FlushCount
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              consume;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        inst_pc_d = inst_pc_q;
        inst_d    = inst_q;
        valid_d   = valid_q;
        consume   = valid_q & bus.InstReady;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (bus.Redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.RedirectPC;
                end else if (!valid_q || bus.InstReady) begin
                    inst_d    = bus.InstIn;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + 1'b1;
                    if (bus.InstIn[INST_W-1 -: OPC_W] == OP_HALT) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A redirect means the halt was fetched down a wrong path.
                if (bus.Redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.RedirectPC;
                    state_d = ST_RUN;
                end else if (consume) begin
                    valid_d = 1'b0;
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_pc_q <= '0;
            inst_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstValid   = valid_q;
    assign bus.Inst        = inst_q;
    assign bus.InstPC      = inst_pc_q;
    assign Halted          = (state_q == ST_HALTED);

`ifdef INST_FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        start_ok;
    logic        flush;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        start_ok    = Start && (state_q == ST_IDLE || state_q == ST_HALTED);
        flush       = bus.Redirect && valid_q && !bus.InstReady;
        if (start_ok) begin
            fetch_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (consume && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
            if (flush && flush_cnt_q != 16'hFFFF)   flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_inst_fetch;
    import isa_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    logic Start;
    logic Halted;
`ifdef INST_FETCH_PERF_EN
    logic [15:0] FetchCount;
    logic [15:0] FlushCount;
`endif

    inst_fetch_if #(.ADDR_W(8), .INST_W(10)) bus ();

    logic [9:0] rom [256];
    int total = 0;
    int bad   = 0;

    assign bus.InstIn = rom[bus.InstAddress];

    always #5 Clk = ~Clk;

    inst_fetch #(.ADDR_W(8), .INST_W(10), .RESET_PC(8'd0)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halted     (Halted),
        .bus        (bus)
`ifdef INST_FETCH_PERF_EN
       ,.FetchCount (FetchCount),
        .FlushCount (FlushCount)
`endif
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_directed_rom();
        for (int i = 0; i < 256; i++) rom[i] = {OP_SUB, 6'(i)};
        rom[7] = 10'b0001000000;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0;
        bus.InstReady = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = 8'd0;
        load_directed_rom();
        step();
        total++; if (bus.InstValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.InstValid); end
        total++; if (bus.Inst !== 10'd0) begin bad++; $display("FAIL reset_inst: got %h want 000", bus.Inst); end
        total++; if (bus.InstPC !== 8'd0) begin bad++; $display("FAIL reset_instpc: got %h want 00", bus.InstPC); end
        total++; if (bus.InstAddress !== 8'd0) begin bad++; $display("FAIL reset_addr: got %h want 00", bus.InstAddress); end
        total++; if (Halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", Halted); end
`ifdef INST_FETCH_PERF_EN
        total++; if ({FetchCount, FlushCount} !== 32'd0) begin bad++; $display("FAIL reset_counters: got %h/%h want 0/0", FetchCount, FlushCount); end
`endif
        Reset = 1'b0;
        step(); step();
        total++; if (bus.InstValid !== 1'b0 || bus.InstAddress !== 8'd0) begin
            bad++; $display("FAIL idle_no_fetch: valid=%b addr=%h want 0/00", bus.InstValid, bus.InstAddress);
        end
    endtask

    task automatic test_stream_halt();
        bus.InstReady = 1'b1;
        Start = 1'b1; step(); Start = 1'b0;
        total++; if (bus.InstValid !== 1'b0) begin bad++; $display("FAIL start_latency: valid=%b want 0 one edge after Start", bus.InstValid); end
        for (int n = 0; n < 8; n++) begin
            step();
            total++; if ({bus.InstValid, bus.InstPC, bus.Inst} !== {1'b1, 8'(n), rom[n]}) begin
                bad++; $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h want 1/%h/%h", n, bus.InstValid, bus.InstPC, bus.Inst, 8'(n), rom[n]);
            end
        end
        step();
        total++; if ({Halted, bus.InstValid, bus.InstAddress} !== {1'b1, 1'b0, 8'd8}) begin
            bad++; $display("FAIL halt_enter: halted=%b valid=%b addr=%h want 1/0/08", Halted, bus.InstValid, bus.InstAddress);
        end
        step(); step();
        total++; if ({Halted, bus.InstAddress} !== {1'b1, 8'd8}) begin
            bad++; $display("FAIL halt_frozen: halted=%b addr=%h want 1/08", Halted, bus.InstAddress);
        end
    endtask

    task automatic test_stall();
        Start = 1'b1; step(); Start = 1'b0;
        bus.InstReady = 1'b1;
        step(); step(); step();
        total++; if ({Halted, bus.InstValid, bus.InstPC} !== {1'b0, 1'b1, 8'd2}) begin
            bad++; $display("FAIL restart_pc2: halted=%b valid=%b pc=%h want 0/1/02", Halted, bus.InstValid, bus.InstPC);
        end
        bus.InstReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({bus.InstValid, bus.InstPC, bus.Inst, bus.InstAddress} !== {1'b1, 8'd2, rom[2], 8'd3}) begin
                bad++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h addr=%h want 1/02/%h/03", i, bus.InstValid, bus.InstPC, bus.Inst, bus.InstAddress, rom[2]);
            end
        end
        bus.InstReady = 1'b1;
        step();
        total++; if ({bus.InstValid, bus.InstPC} !== {1'b1, 8'd3}) begin
            bad++; $display("FAIL stall_release: valid=%b pc=%h want 1/03", bus.InstValid, bus.InstPC);
        end
    endtask

    task automatic test_redirect();
        step();
        total++; if (bus.InstPC !== 8'd4) begin bad++; $display("FAIL redirect_setup: pc=%h want 04", bus.InstPC); end
        bus.Redirect = 1'b1; bus.RedirectPC = 8'd24;
        step();
        bus.Redirect = 1'b0;
        total++; if ({bus.InstValid, bus.InstAddress} !== {1'b0, 8'd24}) begin
            bad++; $display("FAIL redirect_flush: valid=%b addr=%h want 0/18", bus.InstValid, bus.InstAddress);
        end
        step();
        total++; if ({bus.InstValid, bus.InstPC, bus.Inst} !== {1'b1, 8'd24, rom[24]}) begin
            bad++; $display("FAIL redirect_target: valid=%b pc=%h inst=%h want 1/18/%h", bus.InstValid, bus.InstPC, bus.Inst, rom[24]);
        end
    endtask

    task automatic test_drain_redirect();
        bus.Redirect = 1'b1; bus.RedirectPC = 8'd5;
        step();
        bus.Redirect = 1'b0;
        step(); step(); step();
        total++; if ({bus.InstValid, bus.InstPC} !== {1'b1, 8'd7}) begin
            bad++; $display("FAIL drain_setup: valid=%b pc=%h want 1/07", bus.InstValid, bus.InstPC);
        end
        bus.InstReady = 1'b0;
        step(); step();
        total++; if ({Halted, bus.InstValid, bus.InstPC, bus.InstAddress} !== {1'b0, 1'b1, 8'd7, 8'd8}) begin
            bad++; $display("FAIL drain_wait: halted=%b valid=%b pc=%h addr=%h want 0/1/07/08", Halted, bus.InstValid, bus.InstPC, bus.InstAddress);
        end
        bus.Redirect = 1'b1; bus.RedirectPC = 8'd2;
        step();
        bus.Redirect = 1'b0;
        total++; if ({Halted, bus.InstValid, bus.InstAddress} !== {1'b0, 1'b0, 8'd2}) begin
            bad++; $display("FAIL drain_redirect: halted=%b valid=%b addr=%h want 0/0/02", Halted, bus.InstValid, bus.InstAddress);
        end
        step();
        total++; if ({Halted, bus.InstValid, bus.InstPC, bus.Inst} !== {1'b0, 1'b1, 8'd2, rom[2]}) begin
            bad++; $display("FAIL drain_resume: halted=%b valid=%b pc=%h inst=%h want 0/1/02/%h", Halted, bus.InstValid, bus.InstPC, bus.Inst, rom[2]);
        end
        bus.InstReady = 1'b1;
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] exp_pc;
        bus.Redirect = 1'b1; bus.RedirectPC = 8'hFC;
        step();
        bus.Redirect = 1'b0;
        exp_pc = 8'hFC;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if ({bus.InstValid, bus.InstPC} !== {1'b1, exp_pc}) begin
                bad++; $display("FAIL wrap[%0d]: valid=%b pc=%h want 1/%h", i, bus.InstValid, bus.InstPC, exp_pc);
            end
            exp_pc = exp_pc + 8'd1;
        end
        Reset = 1'b1;
        #1;
        total++; if ({bus.InstValid, bus.InstAddress, Halted} !== {1'b0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL async_reset: valid=%b addr=%h halted=%b want 0/00/0", bus.InstValid, bus.InstAddress, Halted);
        end
        step();
        Reset = 1'b0;
        step();
    endtask

`ifdef INST_FETCH_PERF_EN
    task automatic test_perf();
        load_directed_rom();
        bus.InstReady = 1'b1;
        Start = 1'b1; step(); Start = 1'b0;
        step();
        repeat (5) step();
        bus.InstReady = 1'b0; bus.Redirect = 1'b1; bus.RedirectPC = 8'd7;
        step();
        bus.Redirect = 1'b0;
        total++; if ({FetchCount, FlushCount} !== {16'd5, 16'd1}) begin
            bad++; $display("FAIL perf_counts: fetch=%0d flush=%0d want 5/1", FetchCount, FlushCount);
        end
        bus.InstReady = 1'b1;
        step(); step();
        total++; if ({Halted, FetchCount} !== {1'b1, 16'd6}) begin
            bad++; $display("FAIL perf_halt: halted=%b fetch=%0d want 1/6", Halted, FetchCount);
        end
        Start = 1'b1; step(); Start = 1'b0;
        total++; if ({Halted, FetchCount, FlushCount} !== {1'b0, 16'd0, 16'd0}) begin
            bad++; $display("FAIL perf_start_clear: halted=%b fetch=%0d flush=%0d want 0/0/0", Halted, FetchCount, FlushCount);
        end
    endtask
`endif

    // Model: the accepted stream is consecutive addresses from the current PC;
    // redirects retarget the PC, a halt word consumed without redirect stops fetching.
    task automatic test_random();
        logic       running, ev, eh, chk_w, v, ready, redir, st;
        logic [7:0] exp_next, ew_pc, p, rpc;
        logic [9:0] ew_inst, w;
        int         accepts;
        Reset = 1'b1; step(); Reset = 1'b0;
        for (int i = 0; i < 256; i++)
            rom[i] = {($urandom_range(0, 9) == 0) ? OP_HALT : 4'($urandom_range(2, 10)), 6'($urandom)};
        bus.InstReady = 1'b0; bus.Redirect = 1'b0;
        Start = 1'b1; step(); Start = 1'b0;
        running = 1'b1; exp_next = 8'd0; ev = 1'b0; eh = 1'b0; chk_w = 1'b0; accepts = 0;
        ew_pc = 8'd0; ew_inst = 10'd0;
        for (int c = 0; c < 3000; c++) begin
            total++; if (bus.InstValid !== ev) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.InstValid, ev); end
            total++; if (Halted !== eh) begin bad++; $display("FAIL rnd_halted@%0d: got %b want %b", c, Halted, eh); end
            total++; if (bus.InstAddress !== exp_next) begin bad++; $display("FAIL rnd_addr@%0d: got %h want %h", c, bus.InstAddress, exp_next); end
            if (chk_w) begin
                total++; if ({bus.InstPC, bus.Inst} !== {ew_pc, ew_inst}) begin
                    bad++; $display("FAIL rnd_word@%0d: pc=%h inst=%h want %h/%h", c, bus.InstPC, bus.Inst, ew_pc, ew_inst);
                end
            end
            v = bus.InstValid; p = bus.InstPC; w = bus.Inst;
            ready = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 9) == 0);
            rpc   = 8'($urandom);
            st    = running ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            bus.InstReady = ready; bus.Redirect = redir; bus.RedirectPC = rpc; Start = st;
            chk_w = 1'b0;
            if (!running) begin
                if (st) begin running = 1'b1; exp_next = 8'd0; eh = 1'b0; end
                ev = 1'b0;
            end else begin
                if (v && ready) accepts++;
                if (redir) begin
                    ev = 1'b0; exp_next = rpc;
                end else if (v && ready && w[9:6] == OP_HALT) begin
                    running = 1'b0; ev = 1'b0; eh = 1'b1;
                end else if (v && !ready) begin
                    ev = 1'b1; chk_w = 1'b1; ew_pc = p; ew_inst = w;
                end else begin
                    ev = 1'b1; chk_w = 1'b1; ew_pc = exp_next; ew_inst = rom[exp_next];
                    exp_next = exp_next + 8'd1;
                end
            end
            step();
        end
        bus.InstReady = 1'b0; bus.Redirect = 1'b0; Start = 1'b0;
        total++; if (accepts < 300) begin bad++; $display("FAIL rnd_progress: accepts=%0d want >=300", accepts); end
    endtask

    initial begin
        test_reset();
        test_stream_halt();
        test_stall();
        test_redirect();
        test_drain_redirect();
        test_wrap_and_reset();
`ifdef INST_FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
